// File: rtl/reg_file_acc_if.sv
// Request/result/debug bundle for reg_file_acc; master drives requests, slave is the accumulator file.
interface reg_file_acc_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 2,
  parameter int IMM_W = 2
);
  localparam int SELW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [SELW-1:0]  sel;
  logic [1:0]       op;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic [SELW-1:0]  rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_flag;

  modport master (
    output in_valid, sel, op, imm, out_ready, rd_sel,
    input  in_ready, out_valid, result, rd_data, rd_flag
  );

  modport slave (
    input  in_valid, sel, op, imm, out_ready, rd_sel,
    output in_ready, out_valid, result, rd_data, rd_flag
  );
endinterface

// File: rtl/reg_file_acc.sv
// NREGS x WIDTH accumulator file (ADD/SUB/LOAD/CLR), 1-cycle registered {carry,value} result; input stalls while a result is held.
// Define REG_FILE_ACC_SAT_EN to clamp ADD/SUB instead of wrapping.
module reg_file_acc #(
  parameter int WIDTH = 4,
  parameter int NREGS = 2,
  parameter int IMM_W = 2
) (
  input logic           clk,
  input logic           rst,
  reg_file_acc_if.slave bus
);
  localparam int SELW = $clog2(NREGS);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] r_acc [NREGS];
  logic [NREGS-1:0] r_flag;
  logic             r_out_valid;
  logic [WIDTH:0]   r_result;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_flag;

  logic             w_accept;
  logic [SELW-1:0]  w_sel;
  op_e              w_op;
  logic [IMM_W-1:0] w_imm_raw;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_new;
  logic             w_carry;

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_sel        = bus.sel;
  assign w_op         = op_e'(bus.op);
  assign w_imm_raw    = bus.imm;
  assign w_imm        = WIDTH'(w_imm_raw);
  assign w_cur        = r_acc[w_sel];
  assign w_sum        = {1'b0, w_cur} + {1'b0, w_imm};
  // The extra MSB of the extended difference is the borrow (imm > acc).
  assign w_diff       = {1'b0, w_cur} - {1'b0, w_imm};

  always_comb begin
    w_new   = '0;
    w_carry = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_carry = w_sum[WIDTH];
`ifdef REG_FILE_ACC_SAT_EN
        w_new   = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
        w_new   = w_sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        w_carry = w_diff[WIDTH];
`ifdef REG_FILE_ACC_SAT_EN
        w_new   = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
        w_new   = w_diff[WIDTH-1:0];
`endif
      end
      OP_LOAD: w_new = w_imm;
      OP_CLR:  w_new = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_acc[i] <= '0;
      end
      r_flag      <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd_data   <= '0;
      r_rd_flag   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc[w_sel] <= w_new;
        if (w_op == OP_CLR) begin
          r_flag[w_sel] <= 1'b0;
        end else if (w_carry) begin
          r_flag[w_sel] <= 1'b1;
        end
        r_result    <= {w_carry, w_new};
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Reads the pre-write contents when the same entry is written this cycle.
      r_rd_data <= r_acc[bus.rd_sel];
      r_rd_flag <= r_flag[bus.rd_sel];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_flag   = r_rd_flag;
endmodule
